// File: rtl/cd_spi_csr_pkg.sv
// Shared types and constants for the SPI-to-CSR bridge.
package cd_spi_csr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      WR_DATA = 2'd2,
      RD_DATA = 2'd3
   } state_t;

   localparam int CMD_W_BIT    = 7;
   localparam int CMD_ADDR_MSB = 4;
   localparam int CSR_AW       = 5;
   localparam int CSR_DW       = 8;

   function automatic logic [CSR_AW-1:0] cmd_addr(input logic [CSR_DW-1:0] cmd);
      return cmd[CMD_ADDR_MSB:0];
   endfunction

endpackage

// File: rtl/cd_spi_sync.sv
// Multi-flop synchroniser for an asynchronous pin, followed by a history flop
// that yields single-cycle rise/fall pulses in the clk domain.
module cd_spi_sync
   import cd_spi_csr_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              hist_r;

   // Synchroniser chain plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= {STAGES{1'b0}};
         hist_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         hist_r <= sync_r[STAGES-1];
      end
   end

   assign level = sync_r[STAGES-1];
   assign rise  = sync_r[STAGES-1] & ~hist_r;
   assign fall  = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/cd_spi_csr.sv
// SPI mode-0 slave that turns one command byte plus a data burst into CSR
// read/write strobes; all SPI pins are oversampled in the clk domain.
module cd_spi_csr
   import cd_spi_csr_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit ADDR_INC    = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_sck,
   input  logic              spi_nss,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [CSR_AW-1:0] csr_address,
   output logic              csr_read,
   input  logic [CSR_DW-1:0] csr_readdata,
   output logic              csr_write,
   output logic [CSR_DW-1:0] csr_writedata
);

   logic sck_lvl_s, sck_rise_s, sck_fall_s;
   logic nss_lvl_s, nss_rise_s, nss_fall_s;
   logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
   logic nss_act_s, byte_done_s, unused_s;
   logic [CSR_DW-1:0] rx_next_s;

   state_t            state_r;
   logic [2:0]        bit_cnt_r;
   logic [CSR_DW-1:0] rx_shift_r, tx_shift_r;
   logic              rd_pend_r;
   logic              spi_miso_r, spi_miso_oe_r;
   logic [CSR_AW-1:0] csr_address_r;
   logic              csr_read_r, csr_write_r;
   logic [CSR_DW-1:0] csr_writedata_r;

   cd_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .reset(reset), .din(spi_sck),
      .level(sck_lvl_s), .rise(sck_rise_s), .fall(sck_fall_s)
   );

   cd_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (
      .clk(clk), .reset(reset), .din(spi_nss),
      .level(nss_lvl_s), .rise(nss_rise_s), .fall(nss_fall_s)
   );

   cd_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .reset(reset), .din(spi_mosi),
      .level(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
   );

   assign unused_s    = ^{sck_lvl_s, nss_rise_s, mosi_rise_s, mosi_fall_s};
   assign nss_act_s   = ~nss_lvl_s;
   assign rx_next_s   = {rx_shift_r[CSR_DW-2:0], mosi_lvl_s};
   assign byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7);

   // Frame sequencer: command decode, bit shifting and CSR strobe generation.
   // Frames start only on an nss falling edge, so a frame cut by reset is never resumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= IDLE;
         bit_cnt_r       <= 3'd0;
         rx_shift_r      <= 8'h00;
         tx_shift_r      <= 8'h00;
         rd_pend_r       <= 1'b0;
         spi_miso_r      <= 1'b0;
         spi_miso_oe_r   <= 1'b0;
         csr_address_r   <= 5'd0;
         csr_read_r      <= 1'b0;
         csr_write_r     <= 1'b0;
         csr_writedata_r <= 8'h00;
      end else begin
         csr_read_r  <= 1'b0;
         csr_write_r <= 1'b0;
         rd_pend_r   <= csr_read_r;
         if (rd_pend_r) begin
            tx_shift_r <= csr_readdata;
         end
         if (ADDR_INC && csr_write_r) begin
            csr_address_r <= csr_address_r + 5'd1;
         end
         if (!nss_act_s) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 3'd0;
            spi_miso_r    <= 1'b0;
            spi_miso_oe_r <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (nss_fall_s) begin
                     state_r       <= CMD;
                     bit_cnt_r     <= 3'd0;
                     spi_miso_r    <= 1'b0;
                     spi_miso_oe_r <= 1'b1;
                  end
               end
               CMD: begin
                  if (sck_rise_s) begin
                     rx_shift_r <= rx_next_s;
                     bit_cnt_r  <= bit_cnt_r + 3'd1;
                     if (byte_done_s) begin
                        csr_address_r <= cmd_addr(rx_next_s);
                        if (rx_next_s[CMD_W_BIT]) begin
                           state_r <= WR_DATA;
                        end else begin
                           state_r    <= RD_DATA;
                           csr_read_r <= 1'b1;
                        end
                     end
                  end
               end
               WR_DATA: begin
                  if (sck_rise_s) begin
                     rx_shift_r <= rx_next_s;
                     bit_cnt_r  <= bit_cnt_r + 3'd1;
                     if (byte_done_s) begin
                        csr_write_r     <= 1'b1;
                        csr_writedata_r <= rx_next_s;
                     end
                  end
               end
               RD_DATA: begin
                  if (sck_rise_s) begin
                     rx_shift_r <= rx_next_s;
                     bit_cnt_r  <= bit_cnt_r + 3'd1;
                     // Prefetch the next byte; address moves first so the read targets it
                     if (byte_done_s) begin
                        csr_read_r <= 1'b1;
                        if (ADDR_INC) begin
                           csr_address_r <= csr_address_r + 5'd1;
                        end
                     end
                  end
                  if (sck_fall_s) begin
                     spi_miso_r <= tx_shift_r[CSR_DW-1];
                     tx_shift_r <= {tx_shift_r[CSR_DW-2:0], 1'b0};
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign spi_miso      = spi_miso_r;
   assign spi_miso_oe   = spi_miso_oe_r;
   assign csr_address   = csr_address_r;
   assign csr_read      = csr_read_r;
   assign csr_write     = csr_write_r;
   assign csr_writedata = csr_writedata_r;

endmodule

// File: doc/cd_spi_csr.md
Name: cd_spi_csr

Overview:
- SPI-slave to CSR-master bridge that sits directly upstream of the CDBUS core's 5-bit/8-bit CSR port, so an external MCU can drive the IP over SPI.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- spi_sck, spi_nss and spi_mosi are oversampled in the system clock domain; no second clock exists.
- Each SPI frame carries one command byte followed by a burst of data bytes to or from a single CSR address.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on spi_sck, spi_nss and spi_mosi (minimum 2).
- ADDR_INC, 0: 1 = csr_address increments by 1 (mod 32) after each data byte; 0 = fixed address for FIFO-style registers.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_sck  in  1  SPI clock, asynchronous
- spi_nss  in  1  SPI chip select, active low, asynchronous
- spi_mosi  in  1  SPI data in
- spi_miso  out  1  SPI data out
- spi_miso_oe  out  1  MISO output enable; top level tristates when low
- csr_address  out  5  CSR address
- csr_read  out  1  one-cycle read strobe
- csr_readdata  in  8  read data, valid the cycle after csr_read
- csr_write  out  1  one-cycle write strobe
- csr_writedata  out  8  write data

Behaviour:
- Reset: all outputs 0; state IDLE; bit counter 0; shift registers 0.
- Sync and edge detect:
  - Each input passes through SYNC_STAGES flops plus one history flop.
  - sck_rise = synced & ~history; sck_fall = ~synced & history; nss_act = ~synced nss.
  - All three inputs share identical delay, so pin ordering is preserved.
- Clock rate limit: f_sck ≤ f_clk/12 (each SCK half-period ≥ 6 clk).
- States: IDLE, CMD, WR_DATA, RD_DATA.
- IDLE:
  - spi_miso_oe = 0.
  - When nss_act: go to CMD, clear bit counter, spi_miso_oe = 1, spi_miso = 0.
- Any state: if nss goes inactive, return to IDLE next cycle.
  - Partial byte discarded; no strobe issued; spi_miso_oe = 0.
- Bit sampling: on sck_rise, rx_shift = {rx_shift[6:0], mosi_synced}, bit counter += 1.
  - On the 8th rise the byte completes and the counter wraps to 0.
- CMD byte layout: bit7 = W (1 write, 0 read); bits6:5 ignored; bits4:0 = addr.
  - On completion, csr_address = addr.
  - W=1 → WR_DATA.
  - W=0 → RD_DATA, with csr_read pulsed in the next cycle.
- WR_DATA: each completed byte produces the following in the cycle after the 8th-rise detection:
  - csr_write = 1 for exactly one clk;
  - csr_writedata = the byte;
  - if ADDR_INC, csr_address += 1 in the following cycle, wrapping 31 → 0.
- RD_DATA timing:
  - csr_read is high at cycle t.
  - csr_readdata is captured into tx_shift at t+1.
  - Each sck_fall: spi_miso = tx_shift[7], then tx_shift <<= 1.
  - The capture is guaranteed to precede the first falling edge of the byte by the rate limit.
- RD_DATA prefetch:
  - Each completed data byte issues the next csr_read, with address increment first if ADDR_INC.
  - A burst of N data bytes therefore produces N+1 csr_read pulses; the last read value is discarded.
  - Hosts must account for this on side-effecting registers.
- During CMD and WR_DATA, spi_miso stays 0.
- csr_read and csr_write are never high in the same cycle; each strobe lasts exactly 1 clk.
- reset during a frame: immediate return to IDLE with all outputs 0. The frame is not resumed even if nss is still low; a new nss falling edge is required.
- Frames shorter than 8 bits: no CSR access.
- CMD completes and nss rises before any data: for a read, exactly one csr_read has occurred; for a write, none.

Decomposition:
- Package cd_spi_csr_pkg holds:
  - state enum {IDLE, CMD, WR_DATA, RD_DATA};
  - CMD_W_BIT = 7;
  - CMD_ADDR_MSB = 4;
  - CSR_AW = 5;
  - CSR_DW = 8.
- Sub-module cd_spi_sync: parameterised synchroniser plus edge detector, instantiated for sck, nss and mosi. It outputs level, rise and fall.

Test Plan:
- Write a single byte: nss low, send 0x85, 0x3C, nss high → exactly one csr_write with csr_address = 5 and csr_writedata = 0x3C; no csr_read.
- Read burst with ADDR_INC=1: cmd 0x02, 3 dummy bytes, model returns addr*0x11 → MISO bytes 0x22, 0x33, 0x44; 4 csr_read pulses at addresses 2, 3, 4, 5.
- FIFO write with ADDR_INC=0: cmd 0x8A, bytes 0x01..0x04 → 4 csr_write pulses, all at address 0x0A, data in order.
- Abort: cmd 0x81, then nss high after 5 data bits → no csr_write; spi_miso_oe drops within SYNC_STAGES+2 clk.
- Reset mid-frame: assert reset during the 3rd data bit of a write with nss held low → outputs 0; remaining sck edges ignored; the next frame decodes correctly after an nss toggle.
- Rate limit: sck at exactly f_clk/12 with random sync phase, 1000 random read/write frames → scoreboard matches, no missed bits.
